// File: rtl/fanout_broadcast.sv
// Eager broadcast fork: holds one upstream token and delivers it to every
// enabled and selected consumer, each of which may accept in its own cycle.
module fanout_broadcast #(
    parameter int NUM_OUT    = 9,
    parameter int DATA_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [NUM_OUT-1:0]    out_en,
    input  logic [NUM_OUT-1:0]    out_sel,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic [15:0]           tok_count
);

    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_data;
    logic [NUM_OUT-1:0]    r_tgt;
    logic [NUM_OUT-1:0]    r_done;
    logic [15:0]           r_tokCount;

    logic [NUM_OUT-1:0]    w_tgt;
    logic [NUM_OUT-1:0]    w_take;
    logic                  w_release;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_zeroAccept;

    // The route mask is only meaningful at load time; the held token keeps its snapshot.
    assign w_tgt        = out_en & out_sel;
    assign out_valid    = {NUM_OUT{r_full}} & r_tgt & ~r_done;
    assign out_data     = r_data;
    assign w_take       = out_valid & out_ready;
    assign w_release    = r_full & (&(r_done | w_take | ~r_tgt));
    assign in_ready     = ~r_full | w_release;
    assign w_accept     = in_valid & in_ready;
    assign w_load       = w_accept & (|w_tgt);
    assign w_zeroAccept = w_accept & ~(|w_tgt);
    assign tok_count    = r_tokCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full     <= 1'b0;
            r_data     <= '0;
            r_tgt      <= '0;
            r_done     <= '0;
            r_tokCount <= '0;
        end else if (flush) begin
            r_full     <= 1'b0;
            r_data     <= '0;
            r_tgt      <= '0;
            r_done     <= '0;
            r_tokCount <= '0;
        end else begin
            // A load in the release cycle simply overwrites the finished token.
            if (w_load) begin
                r_full <= 1'b1;
                r_data <= in_data;
                r_tgt  <= w_tgt;
                r_done <= '0;
            end else if (w_release) begin
                r_full <= 1'b0;
                r_done <= '0;
            end else if (r_full) begin
                r_done <= r_done | w_take;
            end
            r_tokCount <= r_tokCount + 16'(w_release) + 16'(w_zeroAccept);
        end
    end

endmodule

// File: tb/tb_fanout_broadcast.sv
// Scoreboard bench for fanout_broadcast: accepted tokens are queued with their
// route mask and retired as each consumer port handshakes.
module tb_fanout_broadcast;

    localparam int NOUT = 9;
    localparam int DW   = 17;

    typedef struct {
        logic [DW-1:0]   data;
        logic [NOUT-1:0] tgt;
    } sbEntry_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [NOUT-1:0] out_en;
    logic [NOUT-1:0] out_sel;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic [NOUT-1:0] out_valid;
    logic [NOUT-1:0] out_ready;
    logic [15:0]     tok_count;

    int              testsRun    = 0;
    int              testsFailed = 0;
    sbEntry_t        sbQ[$];
    logic [NOUT-1:0] headServed = '0;
    logic [15:0]     expTok     = '0;
    logic [NOUT-1:0] obsValid;
    logic            obsReady;
    logic [15:0]     tokBase;

    fanout_broadcast #(.NUM_OUT(NOUT), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .out_en    (out_en),
        .out_sel   (out_sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tok_count (tok_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                 input logic [NOUT-1:0] sel, input logic [NOUT-1:0] rdy);
        in_valid  = v;
        in_data   = d;
        out_sel   = sel;
        out_ready = rdy;
    endtask

    // One clock: check outputs against the scoreboard before the edge, then tok_count after it.
    task automatic stepCycle();
        logic [NOUT-1:0] expValid;
        logic [NOUT-1:0] tgt;
        logic            expReady;
        #1;
        obsValid = out_valid;
        obsReady = in_ready;
        if (flush) begin
            @(posedge clk);
            #1;
            sbQ.delete();
            headServed = '0;
            expTok     = '0;
            checkOutput("flushTok", tok_count, expTok);
        end else begin
            expValid = (sbQ.size() != 0) ? (sbQ[0].tgt & ~headServed) : '0;
            checkOutput("outValid", out_valid, expValid);
            for (int i = 0; i < NOUT; i++) begin
                if (out_valid[i] && out_ready[i] && sbQ.size() != 0) begin
                    checkOutput("takeData", out_data, sbQ[0].data);
                    headServed[i] = 1'b1;
                end
            end
            if (sbQ.size() != 0 && (headServed & sbQ[0].tgt) == sbQ[0].tgt) begin
                void'(sbQ.pop_front());
                headServed = '0;
                expTok++;
            end
            expReady = (sbQ.size() == 0);
            checkOutput("inReady", in_ready, expReady);
            if (in_valid && expReady) begin
                tgt = out_en & out_sel;
                if (tgt == '0) expTok++;
                else sbQ.push_back('{data: in_data, tgt: tgt});
            end
            @(posedge clk);
            #1;
            checkOutput("tokCount", tok_count, expTok);
        end
        @(negedge clk);
    endtask

    logic [NOUT-1:0] stagReady [5] = '{9'h001, 9'h000, 9'h004, 9'h000, 9'h002};
    logic [NOUT-1:0] stagValid [5] = '{9'h007, 9'h006, 9'h006, 9'h002, 9'h002};
    logic            stagInRdy [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        out_en = 9'h1FF;
        applyStimulus(1'b0, '0, 9'h007, 9'h1FF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rstInReady", in_ready, 1);
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstData", out_data, 0);
        checkOutput("rstTok", tok_count, 0);
        @(negedge clk);

        // Single broadcast
        applyStimulus(1'b1, 17'h0ABCD, 9'h007, 9'h1FF);
        stepCycle();
        checkOutput("t1Accept", obsReady, 1);
        applyStimulus(1'b0, '0, 9'h007, 9'h1FF);
        stepCycle();
        checkOutput("t1Valid", obsValid, 9'h007);
        checkOutput("t1InReady", obsReady, 1);
        stepCycle();
        checkOutput("t1ValidDrop", obsValid, 0);
        checkOutput("t1Tok", tok_count, 1);

        // Staggered accept with the next token waiting upstream
        applyStimulus(1'b1, 17'h11111, 9'h007, 9'h000);
        stepCycle();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 17'h12222, 9'h007, stagReady[c]);
            stepCycle();
            checkOutput("stagValid", obsValid, stagValid[c]);
            checkOutput("stagInReady", obsReady, stagInRdy[c]);
        end
        applyStimulus(1'b0, '0, 9'h007, 9'h1FF);
        stepCycle();
        checkOutput("stagNext", obsValid, 9'h007);
        stepCycle();

        // Streaming: 100 back-to-back tokens
        tokBase = tok_count;
        for (int n = 0; n < 100; n++) begin
            applyStimulus(1'b1, DW'($urandom), 9'h007, 9'h1FF);
            stepCycle();
        end
        applyStimulus(1'b0, '0, 9'h007, 9'h1FF);
        stepCycle();
        checkOutput("streamDrained", sbQ.size(), 0);
        checkOutput("streamTok", tok_count, tokBase + 16'd100);

        // Zero-target tokens are accepted and counted but never presented
        tokBase = tok_count;
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 17'h1F00F + DW'(n), 9'h000, 9'h1FF);
            stepCycle();
            checkOutput("zeroInReady", obsReady, 1);
            checkOutput("zeroValid", obsValid, 0);
        end
        checkOutput("zeroTok", tok_count, tokBase + 16'd3);

        // Configuration change while a token is held
        applyStimulus(1'b1, 17'h03333, 9'h003, 9'h000);
        stepCycle();
        applyStimulus(1'b0, '0, 9'h003, 9'h000);
        stepCycle();
        stepCycle();
        checkOutput("cfgHeld", obsValid, 9'h003);
        applyStimulus(1'b1, 17'h04444, 9'h1F0, 9'h1FF);
        stepCycle();
        checkOutput("cfgOldTgt", obsValid, 9'h003);
        applyStimulus(1'b0, '0, 9'h1F0, 9'h1FF);
        stepCycle();
        checkOutput("cfgNewTgt", obsValid, 9'h1F0);
        stepCycle();

        // Flush while port 1 is already served
        applyStimulus(1'b1, 17'h05555, 9'h003, 9'h000);
        stepCycle();
        applyStimulus(1'b0, '0, 9'h003, 9'h002);
        stepCycle();
        applyStimulus(1'b0, '0, 9'h003, 9'h000);
        stepCycle();
        checkOutput("flushPre", obsValid, 9'h001);
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        stepCycle();
        checkOutput("flushValid", obsValid, 0);
        checkOutput("flushInReady", obsReady, 1);
        checkOutput("flushData", out_data, 0);

        // Asynchronous reset pulse between edges
        applyStimulus(1'b1, 17'h06666, 9'h003, 9'h000);
        stepCycle();
        applyStimulus(1'b0, '0, 9'h003, 9'h002);
        stepCycle();
        applyStimulus(1'b0, '0, 9'h003, 9'h000);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arstValid", out_valid, 0);
        checkOutput("arstInReady", in_ready, 1);
        checkOutput("arstTok", tok_count, 0);
        sbQ.delete();
        headServed = '0;
        expTok     = '0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        stepCycle();
        checkOutput("arstNoValid", obsValid, 0);

        // Recovery after reset
        applyStimulus(1'b1, 17'h17777, 9'h1F0, 9'h1FF);
        stepCycle();
        applyStimulus(1'b0, '0, 9'h1F0, 9'h1FF);
        stepCycle();
        checkOutput("recoverValid", obsValid, 9'h1F0);
        stepCycle();
        checkOutput("recoverTok", tok_count, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
